// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // ceil(width * log10(2)), with log10(2) taken as 0.30103
    function automatic int unsigned req_digits(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3 (
    input  logic [3:0] d_i,
    input  logic [3:0] d_o_unused_guard_i,
    output logic [3:0] d_o
);

    logic [3:0] sum;

    // The guard input lets the parent tie the cell to a known digit slot; it is not used here.
    always_comb begin
        sum = d_i + 4'd3 + (d_o_unused_guard_i & 4'd0);
        d_o = (d_i >= 4'd5) ? sum : d_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one binary bit per clock.
// Define BIN2BCD_BLANK_EN to replace leading zero digits (above digit 0) with the blank code.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned SW   = BcdW + WIDTH;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (DIGITS != req_digits(WIDTH)) begin : g_bad_digits
        $error("DIGITS does not match the digit count required by WIDTH");
    end

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic [BcdW-1:0]  bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SW-1:0]    adjusted;
    logic [SW-1:0]    shifted;
    logic [BcdW-1:0]  final_bcd;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i                (scratch_q[WIDTH + 4*i +: 4]),
            .d_o_unused_guard_i (4'd0),
            .d_o                (adjusted[WIDTH + 4*i +: 4])
        );
    end

    assign adjusted[WIDTH-1:0] = scratch_q[WIDTH-1:0];
    assign shifted             = adjusted << 1;

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        logic leading;
        final_bcd = shifted[SW-1:WIDTH];
        leading   = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (leading && (final_bcd[4*i +: 4] == 4'h0)) begin
                final_bcd[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign final_bcd = shifted[SW-1:WIDTH];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    scratch_d = {{BcdW{1'b0}}, bin};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + CntW'(1);
                // Last bit: publish the result straight from the shift path
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    bcd_d   = final_bcd;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a reference model predicts results, a monitor compares them.
module tb_bin2bcd_seq;

    localparam int W = 8;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  bin = '0;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;

    bin2bcd_seq #(
        .WIDTH  (W),
        .DIGITS (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*D-1:0] val;
        int             edge_no;
    } exp_t;

    exp_t           sb_q[$];
    int             edge_cnt = 0;
    bit             m_busy = 1'b0;
    int             m_acc_edge = 0;
    logic [4*D-1:0] m_pending = '0;
    logic [4*D-1:0] m_hold = '0;
    int             n_checks = 0;
    int             n_errors = 0;

    function automatic logic [4*D-1:0] ref_bcd(input int v);
        logic [4*D-1:0] r;
        int             rem;
        bit             leading;
        rem = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        leading = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            if (leading && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
            else leading = 1'b0;
        end
`else
        leading = 1'b0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Reference model: decides acceptance and completion from the handshake rules.
    always @(posedge clk) begin
        bit was_busy;
        edge_cnt++;
        if (reset) begin
            sb_q.delete();
            m_busy = 1'b0;
            m_hold = '0;
        end else begin
            was_busy = m_busy;
            if (m_busy && edge_cnt == m_acc_edge + W) begin
                m_hold = m_pending;
                m_busy = 1'b0;
            end
            if (!was_busy && start) begin
                m_busy     = 1'b1;
                m_acc_edge = edge_cnt;
                m_pending  = ref_bcd(int'(bin));
                sb_q.push_back('{val: m_pending, edge_no: edge_cnt + W});
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            check("busy", 32'(busy), 32'(m_busy));
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    check("done_bcd", 32'(bcd), 32'(sb_q[0].val));
                    check("done_edge", 32'(edge_cnt), 32'(sb_q[0].edge_no));
                    void'(sb_q.pop_front());
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                    check("missing_done", 32'(done), 32'd1);
                    void'(sb_q.pop_front());
                end
                check("bcd_hold", 32'(bcd), 32'(m_hold));
            end
        end
    end

    task automatic cyc(input logic s, input int b, input logic r);
        start = s;
        bin   = W'(b);
        reset = r;
        @(negedge clk);
    endtask

    task automatic convert(input int b);
        cyc(1'b1, b, 1'b0);
        repeat (W + 2) cyc(1'b0, $urandom_range(0, 255), 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0);

        convert(0);
        convert(255);
        convert(99);
        convert(128);
        convert(7);
        convert(40);
        convert(100);

        // start while busy must be ignored
        cyc(1'b1, 200, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b1, 17, 1'b0);
        repeat (W + 2) cyc(1'b0, 0, 1'b0);

        // start held across the done cycle
        cyc(1'b1, 42, 1'b0);
        repeat (W + 1) cyc(1'b1, 163, 1'b0);
        repeat (W + 2) cyc(1'b0, 0, 1'b0);

        // reset mid-conversion
        cyc(1'b1, 150, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1);
        repeat (3) cyc(1'b0, 0, 1'b0);
        convert(150);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 59) == 0);
        end
        repeat (W + 3) cyc(1'b0, 0, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble (shift-and-add-3) converter turning an unsigned binary value into packed BCD digits, one bit per clock. It sits directly upstream of the 8-bit 2:1 digit-pair multiplexer. Its registered BCD result supplies the two byte-wide inputs (low pair: ones/tens; high pair: hundreds plus pad) that the display path selects between. Start/done handshake, no back-pressure.

## Interface
- `WIDTH`, 8: binary input width.
- `DIGITS`, 3: BCD digits produced. Must equal ceil(WIDTH·log10 2); 3 for WIDTH=8.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a conversion; sampled only in IDLE.
- `bin` input WIDTH: value to convert; captured on the accepting edge only.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when `bcd` is updated.
- `bcd` output 4·DIGITS: packed BCD, digit 0 (ones) in bits [3:0]; holds the last result.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, shift counter 0, scratch register 0.
- Scratch register is 4·DIGITS+WIDTH bits: BCD field on top, binary field below.
- IDLE:
  - `start`=1 at an edge loads {0, `bin`} into scratch, clears the counter, moves to SHIFT, and sets `busy`=1.
  - `start`=0 stays in IDLE.
- SHIFT, once per edge:
  - Every BCD digit ≥5 gets +3 (4-bit add, no carry out).
  - The whole scratch register then shifts left by 1 and the counter increments.
- SHIFT completion, on the edge where the counter reaches WIDTH-1:
  - The final adjusted-and-shifted BCD field is written to `bcd`.
  - `done`=1, `busy`=0, state returns to IDLE.
- `done` self-clears on the next edge.
- `start` while busy is ignored. The request is not queued and `bin` is not re-sampled.
- `start`=1 during the `done` cycle is accepted, since the state is already IDLE.
- `reset` mid-conversion aborts it. `bcd` returns to 0 and no `done` is issued.
- `bin` may change freely after the accepting edge without affecting the result.
- `bcd` never exhibits intermediate values; it changes only on the `done` edge or on reset.

## Timing
- `start` accepted at edge k. Shifts occur at edges k+1 … k+WIDTH.
- `bcd` is valid and `done`=1 in the cycle following edge k+WIDTH. Latency is WIDTH cycles from the accepting edge (8 for the default).
- `busy` is high for the cycles after edges k … k+WIDTH-1, i.e. exactly WIDTH cycles.
- Maximum throughput: one conversion per WIDTH+1 cycles, with `start` held high continuously.
- Counter width is $clog2(WIDTH). All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `BIN2BCD_BLANK_EN` defined:
  - At the `done` edge, leading zero digits above digit 0 are written as 4'hF (blank code for the downstream segment decoder).
  - Digit 0 is never blanked. Example: 7 → `bcd`=12'hFF7; 40 → 12'hF40; 0 → 12'hFF0.
- Undefined: leading zeros are output as 4'h0 and no blanking logic is synthesised.
- Reset value of `bcd` is 0 in both cases.

## Structure
- Package `bin2bcd_pkg` holds:
  - The state enum (IDLE, SHIFT).
  - Constant `BCD_BLANK` = 4'hF.
  - A constant function computing the required DIGITS from WIDTH, used for an elaboration-time check.
- Sub-module `bcd_add3`: combinational 4-bit "add 3 if ≥5" cell, instantiated once per digit in a generate loop.
- Everything else lives in `bin2bcd_seq`.

## Test plan
- Reset, then `bin`=0 with a `start` pulse → after 8 cycles `done` pulses once, `bcd`=12'h000, `busy` low again.
- `bin`=255 → `bcd`=12'h255. `bin`=99 → 12'h099. `bin`=128 → 12'h128. Check `done` occurs exactly 8 cycles after the accepting edge.
- Start with `bin`=200, re-assert `start` with `bin`=17 at cycle 3 → result 12'h200 only, single `done`, no second conversion.
- Hold `start` high with `bin`=42 then 163 across the `done` cycle → results 12'h042 and 12'h163, 9 cycles apart.
- Assert `reset` at cycle 4 of converting 150 → `busy`=0, `bcd`=0, no `done`. A following conversion of 150 gives 12'h150.
- With `BIN2BCD_BLANK_EN`: `bin`=7 → 12'hFF7, `bin`=0 → 12'hFF0, `bin`=100 → 12'h100.
